// File: rtl/ovl_overflow_stim.sv
// ---------------------------------------------------------------------------
// ovl_overflow_stim
//
// Purpose:
//   Stimulus generator for an ovl_no_overflow checker. On request it runs a
//   fixed-length sequence of RUN_LEN value advances on test_expr. The advance
//   rule depends on the run mode:
//     00 / 11 : count up by one and saturate at MAX
//     01      : count up by one and wrap from MAX to MIN, flagging ovf_pulse
//     10      : start at MAX, count down by one and saturate at MIN
//   A run is followed by a one-cycle DONE state and then a return to IDLE.
//
// Parameters:
//   WIDTH   - bit width of test_expr
//   MIN     - lower bound of the driven range
//   MAX     - upper bound of the driven range (MIN < MAX <= 2**WIDTH-1)
//   RUN_LEN - number of value advances per run (>= 1)
//
// Ports:
//   clock     in   rising-edge clock for all state
//   reset     in   synchronous, active-high reset
//   start     in   run request, sampled only in IDLE
//   mode      in   [1:0] run mode, sampled together with start
//   test_expr out  [WIDTH-1:0] registered value for the checker
//   busy      out  high while in RUN
//   done      out  one-cycle pulse while in DONE
//   ovf_pulse out  one-cycle flag, high in the cycle test_expr shows MIN
//                  after a wrap from MAX
//   ovf_count out  [7:0] saturating count of ovf_pulse assertions, cleared
//                  only by reset (present only with OVL_STIM_OVF_COUNT_EN)
//
// Build option:
//   OVL_STIM_OVF_COUNT_EN - define to add the ovf_count output and counter.
// ---------------------------------------------------------------------------
module ovl_overflow_stim #(
    parameter int WIDTH   = 4,
    parameter int MIN     = 0,
    parameter int MAX     = 15,
    parameter int RUN_LEN = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] test_expr,
    output logic             busy,
    output logic             done,
    output logic             ovf_pulse
`ifdef OVL_STIM_OVF_COUNT_EN
    ,
    output logic [7:0]       ovf_count
`endif
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    // The step counter holds 0..RUN_LEN, so it never has to wrap.
    localparam int STEP_W = $clog2(RUN_LEN + 1);

    localparam logic [WIDTH-1:0]  MIN_V     = WIDTH'(MIN);
    localparam logic [WIDTH-1:0]  MAX_V     = WIDTH'(MAX);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(RUN_LEN - 1);
    localparam logic [STEP_W-1:0] FULL_STEP = STEP_W'(RUN_LEN);

    localparam logic [1:0] MODE_SAT_UP   = 2'b00;
    localparam logic [1:0] MODE_WRAP_UP  = 2'b01;
    localparam logic [1:0] MODE_SAT_DOWN = 2'b10;

    // Reject parameter sets that cannot describe a meaningful range.
    generate
        if ((MIN < 0) || (MIN >= MAX) || (MAX > (2 ** WIDTH) - 1) || (RUN_LEN < 1)) begin : g_bad_params
            $error("ovl_overflow_stim: illegal parameters (need 0 <= MIN < MAX <= 2**WIDTH-1, RUN_LEN >= 1)");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        mode_q;
    logic [STEP_W-1:0] step;

    // Combinational datapath results
    logic [WIDTH-1:0]  adv_value;
    logic              adv_ovf;
    logic [WIDTH-1:0]  entry_value;
    logic              last_advance;

    assign last_advance = (step == LAST_STEP);

    // Mode 10 starts at the top of the range; every other mode starts at the
    // bottom. The live mode input is used because it is latched on this edge.
    assign entry_value = (mode == MODE_SAT_DOWN) ? MAX_V : MIN_V;

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The RUN_LEN-th advance happens on the edge that enters DONE.
                if (last_advance) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Always exactly one cycle, and start is ignored here, which
                // gives one IDLE cycle between back-to-back runs.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Advance rule for the latched mode
    // -----------------------------------------------------------------------
    always_comb begin
        adv_value = test_expr;
        adv_ovf   = 1'b0;
        case (mode_q)
            MODE_WRAP_UP: begin
                if (test_expr >= MAX_V) begin
                    adv_value = MIN_V;
                    adv_ovf   = 1'b1;
                end else begin
                    adv_value = test_expr + 1'b1;
                end
            end
            MODE_SAT_DOWN: begin
                if (test_expr <= MIN_V) begin
                    adv_value = MIN_V;
                end else begin
                    adv_value = test_expr - 1'b1;
                end
            end
            default: begin
                // Modes 00 and 11 are both saturate-up.
                if (test_expr >= MAX_V) begin
                    adv_value = MAX_V;
                end else begin
                    adv_value = test_expr + 1'b1;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: test_expr, ovf_pulse, step counter, latched mode
    // -----------------------------------------------------------------------
    // NOTE: every register here, including the latched mode that is only
    // read in RUN, is given a reset value so behaviour after reset never
    // depends on power-up contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            test_expr <= MIN_V;
            ovf_pulse <= 1'b0;
            step      <= '0;
            mode_q    <= MODE_SAT_UP;
        end else begin
            case (state)
                IDLE: begin
                    ovf_pulse <= 1'b0;
                    if (start) begin
                        mode_q    <= mode;
                        step      <= '0;
                        test_expr <= entry_value;
                    end else begin
                        test_expr <= MIN_V;
                    end
                end
                RUN: begin
                    // ovf_pulse is registered alongside test_expr so it is
                    // high in the same cycle the wrapped MIN is visible.
                    test_expr <= adv_value;
                    ovf_pulse <= adv_ovf;
                    if (step != FULL_STEP) begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    // test_expr held its final value during DONE; IDLE
                    // shows MIN again.
                    test_expr <= MIN_V;
                    ovf_pulse <= 1'b0;
                end
                default: begin
                    test_expr <= MIN_V;
                    ovf_pulse <= 1'b0;
                end
            endcase
        end
    end

`ifdef OVL_STIM_OVF_COUNT_EN
    // -----------------------------------------------------------------------
    // Saturating overflow counter, cleared only by reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_count <= 8'd0;
        end else if (ovf_pulse && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ovl_overflow_stim.sv
// ---------------------------------------------------------------------------
// tb_ovl_overflow_stim
//
// Directed bench for ovl_overflow_stim with WIDTH=4, MIN=0, MAX=15,
// RUN_LEN=20. Inputs are driven and outputs sampled on the falling edge.
// Expected test_expr sequences are written out by hand per mode.
// ---------------------------------------------------------------------------
module tb_ovl_overflow_stim;

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [3:0] test_expr;
    logic       busy;
    logic       done;
    logic       ovf_pulse;
`ifdef OVL_STIM_OVF_COUNT_EN
    logic [7:0] ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-written per-mode sequences: index 0 is the RUN entry value,
    // index 20 is the value held during DONE.
    localparam int SEQ_SAT_UP [21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10,
                                       11, 12, 13, 14, 15, 15, 15, 15, 15, 15};
    localparam int SEQ_WRAP   [21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10,
                                       11, 12, 13, 14, 15, 0, 1, 2, 3, 4};
    localparam int SEQ_DOWN   [21] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5,
                                       4, 3, 2, 1, 0, 0, 0, 0, 0, 0};

    ovl_overflow_stim #(
        .WIDTH   (4),
        .MIN     (0),
        .MAX     (15),
        .RUN_LEN (20)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .test_expr (test_expr),
        .busy      (busy),
        .done      (done),
        .ovf_pulse (ovf_pulse)
`ifdef OVL_STIM_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int seq_val(input int sel, input int i);
        case (sel)
            0:       return SEQ_SAT_UP[i];
            1:       return SEQ_WRAP[i];
            default: return SEQ_DOWN[i];
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".ovf"},       32'(ovf_pulse), 32'd0);
        check({tag, ".test_expr"}, 32'(test_expr), 32'd0);
    endtask

    // One full run starting from IDLE at a falling edge. The mode input is
    // flipped during RUN; the latched mode must be unaffected.
    task automatic run_one(input logic [1:0] m, input int sel, input int ovf_idx);
        string tag;
        start = 1'b1;
        mode  = m;
        @(negedge clock);
        start = 1'b0;
        mode  = ~m;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clock);
            tag = $sformatf("m%0d.run[%0d]", m, i);
            check({tag, ".busy"},      32'(busy),      32'd1);
            check({tag, ".done"},      32'(done),      32'd0);
            check({tag, ".test_expr"}, 32'(test_expr), 32'(seq_val(sel, i)));
            check({tag, ".ovf"},       32'(ovf_pulse), (i == ovf_idx) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        tag = $sformatf("m%0d.done", m);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd1);
        check({tag, ".test_expr"}, 32'(test_expr), 32'(seq_val(sel, 20)));
        check({tag, ".ovf"},       32'(ovf_pulse), (ovf_idx == 20) ? 32'd1 : 32'd0);
        @(negedge clock);
        check_idle($sformatf("m%0d.after", m));
        mode = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        repeat (2) @(negedge clock);
        check_idle("reset");
`ifdef OVL_STIM_OVF_COUNT_EN
        check("reset.ovf_count", 32'(ovf_count), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clock);
        check_idle("idle_no_start");

        // Main function, one run per mode
        run_one(2'b00, 0, -1);
        run_one(2'b01, 1, 16);
        run_one(2'b01, 1, 16);
`ifdef OVL_STIM_OVF_COUNT_EN
        check("two_wraps.ovf_count", 32'(ovf_count), 32'd2);
`endif
        run_one(2'b10, 2, -1);
        run_one(2'b11, 0, -1);

        // Reset in the middle of a wrap-up run
        start = 1'b1;
        mode  = 2'b01;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("midrst.pre.test_expr", 32'(test_expr), 32'd7);
        check("midrst.pre.busy",      32'(busy),      32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_idle("midrst.post");
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            check($sformatf("midrst.no_done[%0d]", i), 32'(done), 32'd0);
        end

        // Reset wins over start in the same cycle
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'b10;
        @(negedge clock);
        check_idle("rst_vs_start");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_idle("rst_vs_start.after");

        // start held high: 20 RUN cycles, 1 DONE, 1 IDLE, repeat
        start = 1'b1;
        mode  = 2'b00;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 22; c++) begin
                @(negedge clock);
                check($sformatf("b2b[%0d][%0d].busy", r, c), 32'(busy), (c < 20) ? 32'd1 : 32'd0);
                check($sformatf("b2b[%0d][%0d].done", r, c), 32'(done), (c == 20) ? 32'd1 : 32'd0);
                if (c == 20) check($sformatf("b2b[%0d].done_val", r), 32'(test_expr), 32'd15);
                if (c == 21) check($sformatf("b2b[%0d].idle_val", r), 32'(test_expr), 32'd0);
            end
        end
        start = 1'b0;
        @(negedge clock);
        check_idle("b2b.stop");

`ifdef OVL_STIM_OVF_COUNT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("final_reset.ovf_count", 32'(ovf_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
